led_column_fetch: RTL and testbench
===================================

// Module: led_column_fetch
// PURPOSE
// - Sits between the SDRAM arbiter and the LED driver: on each column strobe, reads one column of frame data from SDRAM.
// - Issues read addresses on the arbiter read-request/address-ack handshake and collects read data.
// - Writes the data into the LED driver's double-buffered line RAM, then signals completion.
// PARAMETERS
// - COL_WORDS   128   16-bit words per column; power of 2, >= BURST_SIZE.
// - NUM_COLS    128   columns per frame.
// - BURST_SIZE  8     max address acks the arbiter grants per request; power of 2.
// - ADDR_W      24    SDRAM word-address width.
// PORTS
// - SDRAM_CLK   in   1                   Sole clock, rising edge.
// - nReset      in   1                   Asynchronous, active-low reset.
// - colStart    in   1                   1-cycle strobe: fetch column colIndex.
// - colIndex    in   $clog2(NUM_COLS)    Column number; sampled with colStart.
// - frameBase   in   ADDR_W              Frame base word address; sampled with colStart.
// - readReq     out  1                   Request to the arbiter for read address slots.
// - address     out  ADDR_W              Current read word address.
// - addressAck  in   1                   Arbiter consumed address this cycle.
// - readDataValid in 1                   SDRAM read data valid.
// - readData    in   16                  SDRAM read data.
// - bufWren     out  1                   Line-buffer write enable.
// - bufWrAddr   out  $clog2(COL_WORDS)+1 Line-buffer address: {bank, word}.
// - bufWrData   out  16                  Line-buffer write data.
// - colDone     out  1                   1-cycle pulse: column complete; bank flipped.
// - busy        out  1                   High from accepted colStart until colDone.
// - overrun     out  1                   Sticky: colStart arrived while busy.
// BEHAVIOUR
// - Reset values (async): all outputs 0; bank=0; counters 0; state IDLE.
// - States:
//   - IDLE: on colStart, latch base = frameBase + colIndex*COL_WORDS (shift, modulo 2^ADDR_W) and go to FETCH.
//   - FETCH: issue addresses and collect data. When rxCnt reaches COL_WORDS, go to DONE.
//   - DONE: one cycle. colDone=1, bank toggles, then IDLE.
// - Address side:
//   - issCnt counts acks, 0..COL_WORDS.
//   - address = base + issCnt.
//   - readReq = (state==FETCH) && issCnt < COL_WORDS, combinational.
//   - Each cycle with addressAck && readReq: issCnt++.
//   - addressAck while readReq=0 is ignored.
// - Data side:
//   - Each readDataValid in FETCH writes bufWrData=readData at bufWrAddr={bank, rxCnt[low]}; rxCnt++.
//   - Write is registered: 1-cycle latency from readDataValid to bufWren.
//   - readDataValid outside FETCH is dropped.
// - Data may arrive in the same cycle as an ack; both counters update independently.
// - The last data word and the DONE transition: DONE entered the cycle after the final bufWren is registered.
// - busy = state != IDLE.
// - colStart while busy: ignored; overrun set (cleared only by reset).
// - Simultaneous colStart and DONE: treated as busy, so overrun is set.
// - Bank: the LED driver reads bank ~bank. After colDone, the freshly written bank becomes the read bank.
// - Reset mid-FETCH: counters and state return to IDLE immediately. Outstanding SDRAM data arriving afterwards is dropped.
// CONFIGURATION
// - LED_FETCH_OVCNT_EN:
//   - Defined: adds output ovCnt[15:0], counting ignored colStart strobes, saturating at 16'hFFFF, reset 0.
//   - Undefined: port absent; only the sticky overrun flag exists.
// TESTING
// - Basic column:
//   - Stimulus: colStart, colIndex=3, frameBase=0; arbiter acks 8 per grant, data returns 2 cycles later.
//   - Response: addresses 384..511 issued in order; 128 bufWren at {0, 0..127}; one colDone; bank=1.
// - Back-to-back columns:
//   - Stimulus: two columns.
//   - Response: second writes bank 1, i.e. bufWrAddr 128..255; bank back to 0.
// - Throttling:
//   - Stimulus: addressAck held low 50 cycles mid-column.
//   - Response: readReq stays 1; address frozen; no duplicate or skipped address.
// - Overrun:
//   - Stimulus: colStart while busy.
//   - Response: overrun=1; fetch completes unchanged. With LED_FETCH_OVCNT_EN, ovCnt=1.
// - Reset mid-column:
//   - Stimulus: nReset low after 40 acks; late readDataValid after release.
//   - Response: outputs 0 asynchronously; no bufWren afterwards.
// - Address wrap:
//   - Stimulus: frameBase=24'hFFFFC0, colIndex=0.
//   - Response: address wraps to 0 after 24'hFFFFFF.

Source files
------------

// File: rtl/led_column_fetch_if.sv
// led_column_fetch_if: read-address / read-data handshake between the column fetcher (master)
// and the SDRAM arbiter (slave).
interface led_column_fetch_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              readReq;
    logic [ADDR_W-1:0] address;
    logic              addressAck;
    logic              readDataValid;
    logic [15:0]       readData;

    modport master (
        output readReq,
        output address,
        input  addressAck,
        input  readDataValid,
        input  readData
    );

    modport slave (
        input  readReq,
        input  address,
        output addressAck,
        output readDataValid,
        output readData
    );
endinterface

// File: rtl/led_column_fetch.sv
// led_column_fetch: on each column strobe, reads one column of frame data from SDRAM into the LED
// driver's double-buffered line RAM. Define LED_FETCH_OVCNT_EN to add the ovCnt ignored-strobe counter.
module led_column_fetch #(
    parameter int unsigned COL_WORDS  = 128,
    parameter int unsigned NUM_COLS   = 128,
    parameter int unsigned BURST_SIZE = 8,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic                        SDRAM_CLK,
    input  logic                        nReset,
    input  logic                        colStart,
    input  logic [$clog2(NUM_COLS)-1:0] colIndex,
    input  logic [ADDR_W-1:0]           frameBase,
    led_column_fetch_if.master          sdram,
    output logic                        bufWren,
    output logic [$clog2(COL_WORDS):0]  bufWrAddr,
    output logic [15:0]                 bufWrData,
    output logic                        colDone,
    output logic                        busy,
    output logic                        overrun
`ifdef LED_FETCH_OVCNT_EN
    ,
    output logic [15:0]                 ovCnt
`endif
);
    localparam int unsigned WORD_W = $clog2(COL_WORDS);
    localparam int unsigned CNT_W  = WORD_W + 1;
    localparam logic [CNT_W-1:0] LAST_ISS = CNT_W'(COL_WORDS - 1);

    if (COL_WORDS < BURST_SIZE || (COL_WORDS & (COL_WORDS - 1)) != 0 ||
        (BURST_SIZE & (BURST_SIZE - 1)) != 0) begin : gBadParams
        $error("led_column_fetch: COL_WORDS and BURST_SIZE must be powers of 2, COL_WORDS >= BURST_SIZE");
    end

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] issCnt;
    logic [CNT_W-1:0] rxCnt;
    logic             bank;

    // Address and data sides advance independently; the column ends when every word has been written.
    always_ff @(posedge SDRAM_CLK or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            issCnt        <= '0;
            rxCnt         <= '0;
            bank          <= 1'b0;
            sdram.readReq <= 1'b0;
            sdram.address <= '0;
            bufWren       <= 1'b0;
            bufWrAddr     <= '0;
            bufWrData     <= '0;
            colDone       <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
`ifdef LED_FETCH_OVCNT_EN
            ovCnt         <= '0;
`endif
        end else begin
            bufWren <= 1'b0;
            colDone <= 1'b0;

            if (colStart && state != IDLE) begin
                overrun <= 1'b1;
`ifdef LED_FETCH_OVCNT_EN
                if (ovCnt != 16'hFFFF) ovCnt <= ovCnt + 16'd1;
`endif
            end

            case (state)
                IDLE: begin
                    if (colStart) begin
                        sdram.address <= frameBase + (ADDR_W'(colIndex) << WORD_W);
                        issCnt        <= '0;
                        rxCnt         <= '0;
                        sdram.readReq <= 1'b1;
                        busy          <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (sdram.readReq && sdram.addressAck) begin
                        sdram.address <= sdram.address + ADDR_W'(1);
                        issCnt        <= issCnt + CNT_W'(1);
                        if (issCnt == LAST_ISS) sdram.readReq <= 1'b0;
                    end
                    if (sdram.readDataValid && !rxCnt[WORD_W]) begin
                        bufWren   <= 1'b1;
                        bufWrAddr <= {bank, rxCnt[WORD_W-1:0]};
                        bufWrData <= sdram.readData;
                        rxCnt     <= rxCnt + CNT_W'(1);
                    end
                    // Final write was registered last cycle: hand the bank over.
                    if (rxCnt[WORD_W]) begin
                        sdram.readReq <= 1'b0;
                        colDone       <= 1'b1;
                        bank          <= ~bank;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_column_fetch.sv
// tb_led_column_fetch: randomized arbiter/SDRAM model with a column-level reference for addresses,
// line-buffer writes, bank alternation, throttling, overrun and reset behaviour.
module tb_led_column_fetch;
    localparam int unsigned COLW = 128;

    logic        SDRAM_CLK;
    logic        nReset;
    logic        colStart;
    logic [6:0]  colIndex;
    logic [23:0] frameBase;
    logic        bufWren;
    logic [7:0]  bufWrAddr;
    logic [15:0] bufWrData;
    logic        colDone;
    logic        busy;
    logic        overrun;
`ifdef LED_FETCH_OVCNT_EN
    logic [15:0] ovCnt;
`endif

    led_column_fetch_if #(.ADDR_W(24)) sdram ();

    led_column_fetch #(
        .COL_WORDS(128), .NUM_COLS(128), .BURST_SIZE(8), .ADDR_W(24)
    ) dut (
        .SDRAM_CLK(SDRAM_CLK),
        .nReset(nReset),
        .colStart(colStart),
        .colIndex(colIndex),
        .frameBase(frameBase),
        .sdram(sdram),
        .bufWren(bufWren),
        .bufWrAddr(bufWrAddr),
        .bufWrData(bufWrData),
        .colDone(colDone),
        .busy(busy),
        .overrun(overrun)
`ifdef LED_FETCH_OVCNT_EN
        ,
        .ovCnt(ovCnt)
`endif
    );

    initial begin
        SDRAM_CLK = 1'b0;
        forever #5 SDRAM_CLK = ~SDRAM_CLK;
    end

    typedef struct {
        int          due;
        logic [15:0] data;
    } pend_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int expBank = 0;
    int expOv = 0;
    pend_t       pendQ[$];
    logic [23:0] issuedQ[$];
    logic [7:0]  wrAddrQ[$];
    logic [15:0] wrDataQ[$];
    int colAckCnt = 0, doneCnt = 0, doneCyc = 0, lastWrCyc = 0;
    int lateLeft = 0, gapLeft = 0, burstLeft = 8;
    int throttleAt = -1, throttleLeft = 0, throttleSeen = 0, throttleBad = 0;
    logic [23:0] throttleExp = '0;
    int rNAddr, rBadAddr, rNWr, rBadWr, rNDone, rLag;
    bit rTmo;
    logic [23:0] rGotA, rExpA, rGotW, rExpW;

    function automatic logic [15:0] dataOf(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h5A3C;
    endfunction

    // Arbiter + SDRAM: bursts of 8 acks with random gaps, in-order data 2 cycles after each ack.
    initial begin
        sdram.addressAck    = 1'b0;
        sdram.readDataValid = 1'b0;
        sdram.readData      = '0;
        forever begin
            @(posedge SDRAM_CLK);
            #1;
            cyc++;
            while (pendQ.size() > 0 && pendQ[0].due < cyc) pendQ.delete(0);
            if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
                sdram.readDataValid = 1'b1;
                sdram.readData      = pendQ[0].data;
                pendQ.delete(0);
            end else if (lateLeft > 0) begin
                sdram.readDataValid = 1'b1;
                sdram.readData      = 16'hDEAD;
                lateLeft--;
            end else begin
                sdram.readDataValid = 1'b0;
                sdram.readData      = 16'($urandom);
            end
            if (sdram.readReq !== 1'b1) begin
                sdram.addressAck = ($urandom_range(0, 3) == 0);
            end else if (throttleLeft > 0 && colAckCnt == throttleAt) begin
                sdram.addressAck = 1'b0;
                throttleLeft--;
                throttleSeen++;
                if (sdram.address !== throttleExp) throttleBad++;
            end else if (gapLeft > 0) begin
                sdram.addressAck = 1'b0;
                gapLeft--;
            end else begin
                sdram.addressAck = 1'b1;
                issuedQ.push_back(sdram.address);
                pendQ.push_back('{due: cyc + 2, data: dataOf(sdram.address)});
                colAckCnt++;
                burstLeft--;
                if (burstLeft == 0) begin
                    burstLeft = 8;
                    gapLeft   = int'($urandom_range(0, 3));
                end
            end
        end
    end

    always @(negedge SDRAM_CLK) begin
        if (bufWren === 1'b1) begin
            wrAddrQ.push_back(bufWrAddr);
            wrDataQ.push_back(bufWrData);
            lastWrCyc = cyc;
        end
        if (colDone === 1'b1) begin
            doneCnt++;
            doneCyc = cyc;
        end
    end

    // Fetches one column and scores it against the reference column (addresses, writes, bank).
    task automatic runColumn(input logic [6:0] idx, input logic [23:0] base, input int strobeAt, input bit strobeDone);
        logic [23:0] ea;
        logic [7:0]  ew;
        issuedQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
        doneCnt = 0; colAckCnt = 0;
        @(posedge SDRAM_CLK); #1;
        colIndex = idx; frameBase = base; colStart = 1'b1;
        @(posedge SDRAM_CLK); #1;
        colStart = 1'b0; colIndex = 7'($urandom); frameBase = 24'($urandom);
        rTmo = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge SDRAM_CLK);
            colStart = 1'b0;
            if (c == strobeAt) begin colStart = 1'b1; colIndex = ~idx; end
            if (colDone === 1'b1) begin
                rTmo = 1'b0;
                if (strobeDone) colStart = 1'b1;
                break;
            end
        end
        repeat (4) begin @(negedge SDRAM_CLK); colStart = 1'b0; end
        rNAddr = issuedQ.size(); rNWr = wrAddrQ.size(); rNDone = doneCnt; rLag = doneCyc - lastWrCyc;
        rBadAddr = -1; rBadWr = -1;
        for (int i = 0; i < rNAddr && i < int'(COLW); i++) begin
            ea = 24'(base + 24'(idx) * 24'd128 + 24'(i));
            if (issuedQ[i] !== ea && rBadAddr < 0) begin rBadAddr = i; rGotA = issuedQ[i]; rExpA = ea; end
        end
        for (int i = 0; i < rNWr && i < int'(COLW); i++) begin
            ea = 24'(base + 24'(idx) * 24'd128 + 24'(i));
            ew = 8'(expBank * 128 + i);
            if ({wrAddrQ[i], wrDataQ[i]} !== {ew, dataOf(ea)} && rBadWr < 0) begin
                rBadWr = i; rGotW = {wrAddrQ[i], wrDataQ[i]}; rExpW = {ew, dataOf(ea)};
            end
        end
        if (!rTmo) expBank ^= 1;
    endtask

    task automatic test_reset();
        nReset = 1'b0; colStart = 1'b0; colIndex = '0; frameBase = '0;
        repeat (3) @(posedge SDRAM_CLK);
        @(negedge SDRAM_CLK);
        checks++; if ({sdram.readReq, bufWren, colDone, busy, overrun} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", {sdram.readReq, bufWren, colDone, busy, overrun}); end
        checks++; if (sdram.address !== 24'd0) begin errors++; $display("FAIL reset_address: got %h required 000000", sdram.address); end
        checks++; if ({bufWrAddr, bufWrData} !== 24'd0) begin errors++; $display("FAIL reset_bufwr: got %h required 000000", {bufWrAddr, bufWrData}); end
`ifdef LED_FETCH_OVCNT_EN
        checks++; if (ovCnt !== 16'd0) begin errors++; $display("FAIL reset_ovcnt: got %0d required 0", ovCnt); end
`endif
        nReset = 1'b1; expBank = 0; expOv = 0;
        repeat (3) @(negedge SDRAM_CLK);
        checks++; if ({busy, sdram.readReq} !== 2'b00) begin errors++; $display("FAIL idle_quiet: got %b required 00", {busy, sdram.readReq}); end
    endtask

    task automatic test_basic_column();
        runColumn(7'd3, 24'd0, -1, 1'b0);
        checks++; if (rTmo) begin errors++; $display("FAIL basic_timeout: colDone=0 required 1"); end
        checks++; if (rNAddr != 128) begin errors++; $display("FAIL basic_addr_count: got %0d required 128", rNAddr); end
        checks++; if (rNAddr < 128 || issuedQ[0] !== 24'd384 || issuedQ[127] !== 24'd511) begin errors++; $display("FAIL basic_addr_range: got %0d..%0d required 384..511", issuedQ[0], issuedQ[rNAddr > 0 ? rNAddr - 1 : 0]); end
        checks++; if (rBadAddr != -1) begin errors++; $display("FAIL basic_addr_seq: idx %0d got %h required %h", rBadAddr, rGotA, rExpA); end
        checks++; if (rNWr != 128) begin errors++; $display("FAIL basic_wr_count: got %0d required 128", rNWr); end
        checks++; if (rBadWr != -1) begin errors++; $display("FAIL basic_wr_seq: idx %0d got %h required %h", rBadWr, rGotW, rExpW); end
        checks++; if (rNDone != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", rNDone); end
        checks++; if (rLag != 1) begin errors++; $display("FAIL basic_done_lag: got %0d required 1", rLag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            runColumn(7'($urandom), 24'($urandom), -1, 1'b0);
            checks++; if (rNAddr != 128 || rBadAddr != -1) begin errors++; $display("FAIL b2b%0d_addr: count %0d bad idx %0d got %h required %h", k, rNAddr, rBadAddr, rGotA, rExpA); end
            checks++; if (rNWr != 128 || rBadWr != -1) begin errors++; $display("FAIL b2b%0d_wr: count %0d bad idx %0d got %h required %h", k, rNWr, rBadWr, rGotW, rExpW); end
            checks++; if (rNDone != 1 || rTmo) begin errors++; $display("FAIL b2b%0d_done: got %0d required 1", k, rNDone); end
            checks++; if (rNWr < 1 || wrAddrQ[0] !== (k == 0 ? 8'd128 : 8'd0)) begin errors++; $display("FAIL b2b%0d_bank: first bufWrAddr %0d required %0d", k, wrAddrQ[0], k == 0 ? 128 : 0); end
        end
    endtask

    task automatic test_throttling();
        logic [6:0]  idx = 7'($urandom);
        logic [23:0] base = 24'($urandom);
        throttleExp = 24'(base + 24'(idx) * 24'd128 + 24'd60);
        throttleAt = 60; throttleLeft = 50; throttleSeen = 0; throttleBad = 0;
        runColumn(idx, base, -1, 1'b0);
        throttleAt = -1;
        checks++; if (throttleSeen != 50) begin errors++; $display("FAIL thr_readreq_held: held cycles %0d required 50", throttleSeen); end
        checks++; if (throttleBad != 0) begin errors++; $display("FAIL thr_addr_frozen: moved cycles %0d required 0", throttleBad); end
        checks++; if (rNAddr != 128 || rBadAddr != -1) begin errors++; $display("FAIL thr_addr: count %0d bad idx %0d got %h required %h", rNAddr, rBadAddr, rGotA, rExpA); end
        checks++; if (rNWr != 128 || rBadWr != -1) begin errors++; $display("FAIL thr_wr: count %0d bad idx %0d got %h required %h", rNWr, rBadWr, rGotW, rExpW); end
    endtask

    task automatic test_address_wrap();
        runColumn(7'd0, 24'hFFFFC0, -1, 1'b0);
        checks++; if (rNAddr != 128 || rBadAddr != -1) begin errors++; $display("FAIL wrap_addr: count %0d bad idx %0d got %h required %h", rNAddr, rBadAddr, rGotA, rExpA); end
        checks++; if (rNAddr < 65 || issuedQ[63] !== 24'hFFFFFF || issuedQ[64] !== 24'h000000) begin errors++; $display("FAIL wrap_point: got %h,%h required ffffff,000000", issuedQ[63], issuedQ[64]); end
        checks++; if (rNWr != 128 || rBadWr != -1) begin errors++; $display("FAIL wrap_wr: count %0d bad idx %0d got %h required %h", rNWr, rBadWr, rGotW, rExpW); end
    endtask

    task automatic test_overrun();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b required 0", overrun); end
        runColumn(7'($urandom), 24'($urandom), 20, 1'b0);
        expOv++;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        checks++; if (rNAddr != 128 || rBadAddr != -1) begin errors++; $display("FAIL ovr_addr: count %0d bad idx %0d got %h required %h", rNAddr, rBadAddr, rGotA, rExpA); end
        checks++; if (rNWr != 128 || rBadWr != -1 || rNDone != 1) begin errors++; $display("FAIL ovr_wr: count %0d bad idx %0d done %0d required 128/-1/1", rNWr, rBadWr, rNDone); end
`ifdef LED_FETCH_OVCNT_EN
        checks++; if (ovCnt !== 16'(expOv)) begin errors++; $display("FAIL ovr_count: got %0d required %0d", ovCnt, expOv); end
`endif
    endtask

    task automatic test_reset_mid_column();
        issuedQ.delete(); colAckCnt = 0; doneCnt = 0;
        @(posedge SDRAM_CLK); #1;
        colIndex = 7'($urandom); frameBase = 24'($urandom); colStart = 1'b1;
        @(posedge SDRAM_CLK); #1;
        colStart = 1'b0;
        for (int c = 0; c < 2000 && colAckCnt < 40; c++) @(negedge SDRAM_CLK);
        checks++; if (colAckCnt < 40) begin errors++; $display("FAIL rst_mid_acks: got %0d acks required 40", colAckCnt); end
        @(negedge SDRAM_CLK);
        nReset = 1'b0;
        #1;
        checks++; if ({sdram.readReq, bufWren, colDone, busy, overrun} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b required 00000", {sdram.readReq, bufWren, colDone, busy, overrun}); end
        checks++; if ({sdram.address, bufWrAddr, bufWrData} !== 48'd0) begin errors++; $display("FAIL rst_mid_buses: got %h required 0", {sdram.address, bufWrAddr, bufWrData}); end
`ifdef LED_FETCH_OVCNT_EN
        checks++; if (ovCnt !== 16'd0) begin errors++; $display("FAIL rst_mid_ovcnt: got %0d required 0", ovCnt); end
`endif
        repeat (3) @(negedge SDRAM_CLK);
        nReset = 1'b1; wrAddrQ.delete(); wrDataQ.delete(); lateLeft = 5; doneCnt = 0; expBank = 0; expOv = 0;
        repeat (12) @(negedge SDRAM_CLK);
        checks++; if (wrAddrQ.size() != 0) begin errors++; $display("FAIL rst_late_data: bufWren count %0d required 0", wrAddrQ.size()); end
        checks++; if ({busy, sdram.readReq, 1'(doneCnt != 0)} !== 3'b000) begin errors++; $display("FAIL rst_after_idle: got %b required 000", {busy, sdram.readReq, 1'(doneCnt != 0)}); end
    endtask

    task automatic test_done_strobe();
        runColumn(7'($urandom), 24'($urandom), -1, 1'b1);
        expOv++;
        checks++; if (rNAddr != 128 || rBadAddr != -1) begin errors++; $display("FAIL dstb_addr: count %0d bad idx %0d got %h required %h", rNAddr, rBadAddr, rGotA, rExpA); end
        checks++; if (rNWr != 128 || rBadWr != -1) begin errors++; $display("FAIL dstb_wr: count %0d bad idx %0d got %h required %h", rNWr, rBadWr, rGotW, rExpW); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL dstb_overrun: got %b required 1", overrun); end
        checks++; if ({busy, sdram.readReq} !== 2'b00) begin errors++; $display("FAIL dstb_no_restart: got %b required 00", {busy, sdram.readReq}); end
`ifdef LED_FETCH_OVCNT_EN
        checks++; if (ovCnt !== 16'(expOv)) begin errors++; $display("FAIL dstb_ovcnt: got %0d required %0d", ovCnt, expOv); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_column();
        test_back_to_back();
        test_throttling();
        test_address_wrap();
        test_overrun();
        test_reset_mid_column();
        test_done_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
